alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: OP_MUL, 5'b01110, ALU opcode of multiply (two-word result).
REQ-002 Parameter: OP_DIV, 5'b01111, ALU opcode of divide (two-word result).
REQ-003 Parameter: OP_NEG, 5'b10000, ALU opcode of negate (unary).
REQ-004 Parameter: OP_NOT, 5'b10001, ALU opcode of bitwise not (unary).
REQ-005 Port: clock  in  1  single clock; all state changes on rising edge.
REQ-006 Port: clear  in  1  reset, asynchronous, active-low.
REQ-007 Port: req_valid  in  1  operation request present.
REQ-008 Port: req_ready  out  1  sequencer idle, request acceptable.
REQ-009 Port: op  in  5  ALU opcode of requested operation.
REQ-010 Port: ra_sel, rb_sel, rc_sel  in  4 each  source A, source B, destination register numbers.
REQ-011 Port: use_imm  in  1  second operand from immediate (c_out) instead of rb_sel.
REQ-012 Port: r_out_sel  out  4  register number driven onto bus when r_out_en=1.
REQ-013 Port: r_out_en, c_out, zlo_out, zhi_out  out  1 each  bus driver strobes.
REQ-014 Port: ry_in, z_in, lo_in, hi_in  out  1 each  Y, Z, LO, HI register load strobes.
REQ-015 Port: r_in_sel  out  4 / r_in_en  out  1  register-file write select and enable.
REQ-016 Port: alu_op  out  5  opcode presented to ALU; 5'b00000 when not in T2.
REQ-017 Port: done  out  1  one-cycle pulse in final cycle of each operation.

Function
REQ-018 States SHALL be IDLE, T1, T2, T3, T4; Moore outputs decoded from state and latched request.
REQ-019 req_ready SHALL be 1 exactly when state is IDLE.
REQ-020 Acceptance SHALL occur on a rising edge with req_valid=1 and req_ready=1; op, ra_sel, rb_sel, rc_sel, use_imm latched then; inputs ignored outside acceptance.
REQ-021 Classes: unary = op in {OP_NEG, OP_NOT}; wide = op in {OP_MUL, OP_DIV}; binary = all others.
REQ-022 Transitions: IDLE->T1 (binary, wide) or IDLE->T2 (unary) on acceptance; T1->T2; T2->T3; T3->IDLE (unary, binary) or T3->T4 (wide); T4->IDLE.
REQ-023 T1: r_out_en=1, r_out_sel=ra_sel, ry_in=1.
REQ-024 T2 binary: c_out=1 if use_imm else r_out_en=1 with r_out_sel=rb_sel; alu_op=op; z_in=1.
REQ-025 T2 unary: r_out_en=1, r_out_sel=ra_sel; alu_op=op; z_in=1; use_imm ignored.
REQ-026 T2 wide: r_out_en=1, r_out_sel=rb_sel; alu_op=op; z_in=1; use_imm ignored.
REQ-027 T3: zlo_out=1; wide: lo_in=1; otherwise r_in_en=1, r_in_sel=rc_sel, done=1.
REQ-028 T4: zhi_out=1, hi_in=1, done=1; rc_sel unused for wide ops.
REQ-029 At most one of r_out_en, c_out, zlo_out, zhi_out SHALL be 1 in any cycle.
REQ-030 All strobes, done, alu_op, r_out_sel, r_in_sel SHALL be 0 in IDLE.
REQ-031 Latency from acceptance edge to done cycle: unary 2, binary 3, wide 4 cycles.
REQ-032 Back-to-back: minimum one IDLE cycle between done and next acceptance; req_valid held high is accepted at the first IDLE edge.
REQ-033 rc_sel equal to ra_sel or rb_sel SHALL be legal; write occurs only in T3, after reads.

Reset
REQ-034 clear=0 SHALL force state IDLE and all outputs to 0 except req_ready=1, immediately, independent of clock.
REQ-035 Reset mid-operation SHALL abandon the operation with no further strobes and no done pulse.
REQ-036 First acceptance after clear deasserts SHALL occur no earlier than the first rising edge with clear=1.

Verification
REQ-037 Binary op=5'b00011, ra=2, rb=3, rc=4, use_imm=0 -> T1 r_out_sel=2 ry_in; T2 r_out_sel=3 z_in alu_op=00011; T3 r_in_sel=4 r_in_en done; 3 cycles.
REQ-038 Immediate op=5'b00011, use_imm=1 -> T2 c_out=1, r_out_en=0; otherwise as REQ-037.
REQ-039 op=OP_MUL, ra=5, rb=6 -> T3 zlo_out lo_in, no r_in_en; T4 zhi_out hi_in done; 4 cycles.
REQ-040 op=OP_NEG, ra=7, rc=1 -> no T1; T2 r_out_sel=7 z_in; T3 r_in_sel=1 done; 2 cycles.
REQ-041 clear pulsed low during T2 of OP_DIV -> outputs 0 at once, req_ready=1, no done, no hi_in/lo_in.
REQ-042 req_valid held high for two binary requests -> done, one IDLE cycle, second T1; bus-driver one-hot checked every cycle.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Request handshake and datapath control strobes between a requester and the ALU sequencer.
// The slave side is the sequencer; the master side issues requests and consumes strobes.
interface alu_sequencer_if;
   logic       req_valid;
   logic       req_ready;
   logic [4:0] op;
   logic [3:0] ra_sel;
   logic [3:0] rb_sel;
   logic [3:0] rc_sel;
   logic       use_imm;
   logic [3:0] r_out_sel;
   logic       r_out_en;
   logic       c_out;
   logic       zlo_out;
   logic       zhi_out;
   logic       ry_in;
   logic       z_in;
   logic       lo_in;
   logic       hi_in;
   logic [3:0] r_in_sel;
   logic       r_in_en;
   logic [4:0] alu_op;
   logic       done;

   modport master (
      output req_valid, op, ra_sel, rb_sel, rc_sel, use_imm,
      input  req_ready, r_out_sel, r_out_en, c_out, zlo_out, zhi_out,
             ry_in, z_in, lo_in, hi_in, r_in_sel, r_in_en, alu_op, done
   );

   modport slave (
      input  req_valid, op, ra_sel, rb_sel, rc_sel, use_imm,
      output req_ready, r_out_sel, r_out_en, c_out, zlo_out, zhi_out,
             ry_in, z_in, lo_in, hi_in, r_in_sel, r_in_en, alu_op, done
   );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer for a single-bus ALU datapath: steps one request through
// T1..T4, driving Moore-decoded bus strobes from the current state and the latched request.
module alu_sequencer #(
   parameter logic [4:0] OP_MUL = 5'b01110,
   parameter logic [4:0] OP_DIV = 5'b01111,
   parameter logic [4:0] OP_NEG = 5'b10000,
   parameter logic [4:0] OP_NOT = 5'b10001
) (
   input  logic           clock,
   input  logic           clear,
   alu_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_T4   = 3'd4
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [4:0] r_op;
   logic [3:0] r_ra_sel;
   logic [3:0] r_rb_sel;
   logic [3:0] r_rc_sel;
   logic       r_use_imm;

   logic w_accept;
   logic w_req_unary;
   logic w_unary;
   logic w_wide;

   assign w_accept    = bus.req_valid && (r_state == S_IDLE);
   // Unary ops skip T1 since their single operand goes straight onto the bus in T2.
   assign w_req_unary = (bus.op == OP_NEG) || (bus.op == OP_NOT);
   assign w_unary     = (r_op == OP_NEG) || (r_op == OP_NOT);
   assign w_wide      = (r_op == OP_MUL) || (r_op == OP_DIV);

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         r_op      <= 5'b00000;
         r_ra_sel  <= 4'd0;
         r_rb_sel  <= 4'd0;
         r_rc_sel  <= 4'd0;
         r_use_imm <= 1'b0;
      end else if (w_accept) begin
         r_op      <= bus.op;
         r_ra_sel  <= bus.ra_sel;
         r_rb_sel  <= bus.rb_sel;
         r_rc_sel  <= bus.rc_sel;
         r_use_imm <= bus.use_imm;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = w_req_unary ? S_T2 : S_T1;
         S_T1:    w_next = S_T2;
         S_T2:    w_next = S_T3;
         S_T3:    w_next = w_wide ? S_T4 : S_IDLE;
         S_T4:    w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = 1'b0;
      bus.r_out_sel = 4'd0;
      bus.r_out_en  = 1'b0;
      bus.c_out     = 1'b0;
      bus.zlo_out   = 1'b0;
      bus.zhi_out   = 1'b0;
      bus.ry_in     = 1'b0;
      bus.z_in      = 1'b0;
      bus.lo_in     = 1'b0;
      bus.hi_in     = 1'b0;
      bus.r_in_sel  = 4'd0;
      bus.r_in_en   = 1'b0;
      bus.alu_op    = 5'b00000;
      bus.done      = 1'b0;
      case (r_state)
         S_IDLE: bus.req_ready = 1'b1;
         S_T1: begin
            bus.r_out_en  = 1'b1;
            bus.r_out_sel = r_ra_sel;
            bus.ry_in     = 1'b1;
         end
         S_T2: begin
            bus.alu_op = r_op;
            bus.z_in   = 1'b1;
            if (w_unary) begin
               bus.r_out_en  = 1'b1;
               bus.r_out_sel = r_ra_sel;
            end else if (w_wide || !r_use_imm) begin
               bus.r_out_en  = 1'b1;
               bus.r_out_sel = r_rb_sel;
            end else begin
               bus.c_out = 1'b1;
            end
         end
         S_T3: begin
            bus.zlo_out = 1'b1;
            // Wide results park the low word in LO; the register file is written only for narrow ops.
            if (w_wide) begin
               bus.lo_in = 1'b1;
            end else begin
               bus.r_in_en  = 1'b1;
               bus.r_in_sel = r_rc_sel;
               bus.done     = 1'b1;
            end
         end
         S_T4: begin
            bus.zhi_out = 1'b1;
            bus.hi_in   = 1'b1;
            bus.done    = 1'b1;
         end
         default: bus.req_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a vector table of requests with per-cycle expected
// strobe words, plus hand-written reset-release, mid-operation reset and back-to-back sequences.
module tb_alu_sequencer;

   logic clock = 1'b0;
   logic clear = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   alu_sequencer_if bus ();

   alu_sequencer dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0]       op;
      logic [3:0]       ra;
      logic [3:0]       rb;
      logic [3:0]       rc;
      logic             imm;
      int               n;
      logic [3:0][22:0] exp;
   } vec_t;

   vec_t vecs [8];

   // Expected strobe word layout: {r_out_en,c_out,zlo_out,zhi_out,ry_in,z_in,lo_in,hi_in,r_in_en,done,r_out_sel,r_in_sel,alu_op}
   function automatic logic [22:0] ow(input logic roe, input logic co, input logic zlo, input logic zhi,
                                      input logic ry, input logic z, input logic lo, input logic hi,
                                      input logic rie, input logic dn, input logic [3:0] rs,
                                      input logic [3:0] ws, input logic [4:0] ao);
      return {roe, co, zlo, zhi, ry, z, lo, hi, rie, dn, rs, ws, ao};
   endfunction

   function automatic logic [22:0] got_word();
      return {bus.r_out_en, bus.c_out, bus.zlo_out, bus.zhi_out, bus.ry_in, bus.z_in,
              bus.lo_in, bus.hi_in, bus.r_in_en, bus.done, bus.r_out_sel, bus.r_in_sel, bus.alu_op};
   endfunction

   task automatic chk(input string nm, input logic [22:0] exp, input logic exp_rdy);
      logic [22:0] got;
      int          drivers;
      got = got_word();
      n_vec++;
      if (got !== exp || bus.req_ready !== exp_rdy) begin
         n_err++;
         $display("FAIL %s: strobes=%h ready=%b, expected strobes=%h ready=%b",
                  nm, got, bus.req_ready, exp, exp_rdy);
      end
      drivers = $countones({bus.r_out_en, bus.c_out, bus.zlo_out, bus.zhi_out});
      n_vec++;
      if (drivers > 1) begin
         n_err++;
         $display("FAIL %s_onehot: %0d bus drivers active, expected at most 1", nm, drivers);
      end
   endtask

   task automatic set_vec(input int i, input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [3:0] rc, input logic imm, input int n,
                          input logic [22:0] e0, input logic [22:0] e1,
                          input logic [22:0] e2, input logic [22:0] e3);
      vecs[i].op  = op;
      vecs[i].ra  = ra;
      vecs[i].rb  = rb;
      vecs[i].rc  = rc;
      vecs[i].imm = imm;
      vecs[i].n   = n;
      vecs[i].exp = {e3, e2, e1, e0};
   endtask

   task automatic drive_req(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                            input logic [3:0] rc, input logic imm);
      bus.req_valid = 1'b1;
      bus.op        = op;
      bus.ra_sel    = ra;
      bus.rb_sel    = rb;
      bus.rc_sel    = rc;
      bus.use_imm   = imm;
   endtask

   task automatic scramble();
      bus.req_valid = 1'b0;
      bus.op        = 5'($urandom);
      bus.ra_sel    = 4'($urandom);
      bus.rb_sel    = 4'($urandom);
      bus.rc_sel    = 4'($urandom);
      bus.use_imm   = 1'($urandom);
   endtask

   task automatic run_vec(input int i);
      @(negedge clock);
      drive_req(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rc, vecs[i].imm);
      chk($sformatf("v%0d_pre", i), 23'd0, 1'b1);
      @(posedge clock);
      #1;
      scramble();
      chk($sformatf("v%0d_c0", i), vecs[i].exp[0], 1'b0);
      for (int k = 1; k < vecs[i].n; k++) begin
         @(posedge clock);
         #1;
         chk($sformatf("v%0d_c%0d", i, k), vecs[i].exp[k], 1'b0);
      end
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_idle", i), 23'd0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [22:0] z;
      z = 23'd0;

      // binary reg/reg, binary immediate, MUL, NEG, NOT, DIV with use_imm, rc==ra==rb, unlisted op with imm
      set_vec(0, 5'b00011, 4'd2, 4'd3, 4'd4, 1'b0, 3,
              ow(1,0,0,0,1,0,0,0,0,0, 4'd2, 4'd0, 5'b00000),
              ow(1,0,0,0,0,1,0,0,0,0, 4'd3, 4'd0, 5'b00011),
              ow(0,0,1,0,0,0,0,0,1,1, 4'd0, 4'd4, 5'b00000), z);
      set_vec(1, 5'b00011, 4'd2, 4'd3, 4'd4, 1'b1, 3,
              ow(1,0,0,0,1,0,0,0,0,0, 4'd2, 4'd0, 5'b00000),
              ow(0,1,0,0,0,1,0,0,0,0, 4'd0, 4'd0, 5'b00011),
              ow(0,0,1,0,0,0,0,0,1,1, 4'd0, 4'd4, 5'b00000), z);
      set_vec(2, 5'b01110, 4'd5, 4'd6, 4'd9, 1'b0, 4,
              ow(1,0,0,0,1,0,0,0,0,0, 4'd5, 4'd0, 5'b00000),
              ow(1,0,0,0,0,1,0,0,0,0, 4'd6, 4'd0, 5'b01110),
              ow(0,0,1,0,0,0,1,0,0,0, 4'd0, 4'd0, 5'b00000),
              ow(0,0,0,1,0,0,0,1,0,1, 4'd0, 4'd0, 5'b00000));
      set_vec(3, 5'b10000, 4'd7, 4'd2, 4'd1, 1'b1, 2,
              ow(1,0,0,0,0,1,0,0,0,0, 4'd7, 4'd0, 5'b10000),
              ow(0,0,1,0,0,0,0,0,1,1, 4'd0, 4'd1, 5'b00000), z, z);
      set_vec(4, 5'b10001, 4'd15, 4'd0, 4'd15, 1'b0, 2,
              ow(1,0,0,0,0,1,0,0,0,0, 4'd15, 4'd0, 5'b10001),
              ow(0,0,1,0,0,0,0,0,1,1, 4'd0, 4'd15, 5'b00000), z, z);
      set_vec(5, 5'b01111, 4'd1, 4'd14, 4'd3, 1'b1, 4,
              ow(1,0,0,0,1,0,0,0,0,0, 4'd1, 4'd0, 5'b00000),
              ow(1,0,0,0,0,1,0,0,0,0, 4'd14, 4'd0, 5'b01111),
              ow(0,0,1,0,0,0,1,0,0,0, 4'd0, 4'd0, 5'b00000),
              ow(0,0,0,1,0,0,0,1,0,1, 4'd0, 4'd0, 5'b00000));
      set_vec(6, 5'b00000, 4'd0, 4'd0, 4'd0, 1'b0, 3,
              ow(1,0,0,0,1,0,0,0,0,0, 4'd0, 4'd0, 5'b00000),
              ow(1,0,0,0,0,1,0,0,0,0, 4'd0, 4'd0, 5'b00000),
              ow(0,0,1,0,0,0,0,0,1,1, 4'd0, 4'd0, 5'b00000), z);
      set_vec(7, 5'b11111, 4'd10, 4'd11, 4'd10, 1'b1, 3,
              ow(1,0,0,0,1,0,0,0,0,0, 4'd10, 4'd0, 5'b00000),
              ow(0,1,0,0,0,1,0,0,0,0, 4'd0, 4'd0, 5'b11111),
              ow(0,0,1,0,0,0,0,0,1,1, 4'd0, 4'd10, 5'b00000), z);

      // Held in reset with a request pending: must stay idle across an edge.
      drive_req(5'b00011, 4'd2, 4'd3, 4'd4, 1'b0);
      #1;
      chk("reset", z, 1'b1);
      @(posedge clock);
      #1;
      chk("reset_hold", z, 1'b1);

      // Release with req_valid still high: first edge with clear=1 accepts.
      @(negedge clock);
      clear = 1'b1;
      @(posedge clock);
      #1;
      scramble();
      chk("rel_t1", vecs[0].exp[0], 1'b0);
      @(posedge clock);
      #1;
      chk("rel_t2", vecs[0].exp[1], 1'b0);
      @(posedge clock);
      #1;
      chk("rel_t3", vecs[0].exp[2], 1'b0);
      @(posedge clock);
      #1;
      chk("rel_idle", z, 1'b1);

      for (int i = 0; i < 8; i++) run_vec(i);

      // Reset during T2 of DIV: outputs drop at once, no LO/HI load or done afterwards.
      @(negedge clock);
      drive_req(5'b01111, 4'd1, 4'd14, 4'd3, 1'b0);
      @(posedge clock);
      #1;
      scramble();
      chk("rst_t1", vecs[5].exp[0], 1'b0);
      @(posedge clock);
      #1;
      chk("rst_t2", vecs[5].exp[1], 1'b0);
      #2;
      clear = 1'b0;
      #1;
      chk("rst_async", z, 1'b1);
      @(posedge clock);
      #1;
      chk("rst_held", z, 1'b1);
      @(negedge clock);
      clear = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clock);
         #1;
         chk($sformatf("rst_after%0d", k), z, 1'b1);
      end

      // Back-to-back with req_valid held high: one idle cycle between done and second T1.
      @(negedge clock);
      drive_req(5'b00011, 4'd2, 4'd3, 4'd4, 1'b0);
      @(posedge clock);
      #1;
      drive_req(5'b00101, 4'd8, 4'd9, 4'd10, 1'b1);
      chk("b2b_a_t1", ow(1,0,0,0,1,0,0,0,0,0, 4'd2, 4'd0, 5'b00000), 1'b0);
      @(posedge clock);
      #1;
      chk("b2b_a_t2", ow(1,0,0,0,0,1,0,0,0,0, 4'd3, 4'd0, 5'b00011), 1'b0);
      @(posedge clock);
      #1;
      chk("b2b_a_t3", ow(0,0,1,0,0,0,0,0,1,1, 4'd0, 4'd4, 5'b00000), 1'b0);
      @(posedge clock);
      #1;
      chk("b2b_gap", z, 1'b1);
      @(posedge clock);
      #1;
      scramble();
      chk("b2b_b_t1", ow(1,0,0,0,1,0,0,0,0,0, 4'd8, 4'd0, 5'b00000), 1'b0);
      @(posedge clock);
      #1;
      chk("b2b_b_t2", ow(0,1,0,0,0,1,0,0,0,0, 4'd0, 4'd0, 5'b00101), 1'b0);
      @(posedge clock);
      #1;
      chk("b2b_b_t3", ow(0,0,1,0,0,0,0,0,1,1, 4'd0, 4'd10, 5'b00000), 1'b0);
      @(posedge clock);
      #1;
      chk("b2b_idle", z, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
